pipe_stage_skidreg: RTL and testbench

- Parametrised, elastic successor to the fixed EX/MEM pipeline register: one pipeline stage register with valid/ready handshake, a one-entry skid buffer, synchronous flush and bubble-safe control masking.
- Sits between any two CPU stages (EX/MEM first), so a downstream stall (e.g. a memory wait) back-pressures upstream without losing or duplicating an instruction.
- Carries the control bits, ALU result, store operand and destination register number, as the current EX/MEM register does.

---
 rtl/pipe_stage_skidreg.sv | 109 ++++++++++
 tb/tb_pipe_stage_skidreg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skidreg.sv
// Elastic pipeline stage: main register plus one-entry skid buffer, valid/ready
// handshake with registered in_ready, synchronous flush and bubble-safe control masking.
module pipe_stage_skidreg #(
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       RN_W    = 5,
    parameter int unsigned       CTRL_W  = 3,
    parameter logic [CTRL_W-1:0] WE_MASK = 3'b101
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_b,
    input  logic [RN_W-1:0]   in_rn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_b,
    output logic [RN_W-1:0]   out_rn,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] b;
        logic [RN_W-1:0]   rn;
    } entry_t;

    entry_t     m_q, m_d, s_q, s_d, in_e;
    logic       m_vld_q, m_vld_d, s_vld_q, s_vld_d;
    logic       rdy_q, rdy_d;
    logic [1:0] occ_q, occ_d;
    logic       accept, drain, m_load;

    always_comb begin
        in_e.ctrl = in_ctrl;
        in_e.alu  = in_alu;
        in_e.b    = in_b;
        in_e.rn   = in_rn;

        accept = in_valid & rdy_q;
        drain  = m_vld_q & out_ready;
        m_load = !m_vld_q | drain;

        m_d     = m_q;
        m_vld_d = m_vld_q;
        s_d     = s_q;
        s_vld_d = s_vld_q;

        if (flush) begin
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else begin
            if (m_load) begin
                if (s_vld_q) begin
                    m_d     = s_q;
                    m_vld_d = 1'b1;
                end else if (accept) begin
                    m_d     = in_e;
                    m_vld_d = 1'b1;
                end else begin
                    m_vld_d = 1'b0;
                end
            end
            // S valid implies M valid, so S only ever holds the younger of two entries.
            if (accept && (!m_load || s_vld_q)) begin
                s_d     = in_e;
                s_vld_d = 1'b1;
            end else if (m_load && s_vld_q) begin
                s_vld_d = 1'b0;
            end
        end

        rdy_d = !s_vld_d;
        occ_d = {1'b0, m_vld_d} + {1'b0, s_vld_d};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_q     <= '0;
            s_q     <= '0;
            m_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
            rdy_q   <= 1'b1;
            occ_q   <= '0;
        end else begin
            m_q     <= m_d;
            s_q     <= s_d;
            m_vld_q <= m_vld_d;
            s_vld_q <= s_vld_d;
            rdy_q   <= rdy_d;
            occ_q   <= occ_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = m_vld_q;
    assign out_ctrl  = m_q.ctrl & ~(m_vld_q ? {CTRL_W{1'b0}} : WE_MASK);
    assign out_alu   = m_q.alu;
    assign out_b     = m_q.b;
    assign out_rn    = m_q.rn;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_skidreg.sv
// Bench for pipe_stage_skidreg: a 2-deep FIFO model checked every cycle,
// directed scenarios with literal expectations, and a wide-parameter instance.
module tb_pipe_stage_skidreg;

    logic        clock;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [2:0]  in_ctrl, out_ctrl;
    logic [31:0] in_alu, in_b, out_alu, out_b;
    logic [4:0]  in_rn, out_rn;
    logic [1:0]  occupancy;

    logic        w_reset, w_flush, w_in_valid, w_out_ready, w_in_ready, w_out_valid;
    logic [3:0]  w_in_ctrl, w_out_ctrl;
    logic [63:0] w_in_alu, w_in_b, w_out_alu, w_out_b;
    logic [5:0]  w_in_rn, w_out_rn;
    logic [1:0]  w_occupancy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    pipe_stage_skidreg dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_alu(in_alu), .in_b(in_b), .in_rn(in_rn),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_alu(out_alu), .out_b(out_b), .out_rn(out_rn),
        .occupancy(occupancy)
    );

    pipe_stage_skidreg #(
        .DATA_W(64), .RN_W(6), .CTRL_W(4), .WE_MASK(4'b1001)
    ) dut_w (
        .clock(clock), .reset(w_reset), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_ctrl(w_in_ctrl), .in_alu(w_in_alu), .in_b(w_in_b), .in_rn(w_in_rn),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_ctrl(w_out_ctrl), .out_alu(w_out_alu), .out_b(w_out_b), .out_rn(w_out_rn),
        .occupancy(w_occupancy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
    } ent_t;

    // Model: the stage behaves as a 2-deep FIFO; the last shown entry lingers on the outputs.
    ent_t q[$];
    ent_t last = '0;
    bit   mrdy = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        ent_t e;
        bit   acc, drn;
        if (reset) begin
            q.delete();
            last = '0;
            mrdy = 1'b1;
        end else if (flush) begin
            q.delete();
            mrdy = 1'b1;
        end else begin
            acc = in_valid && mrdy;
            drn = (q.size() > 0) && out_ready;
            if (drn) void'(q.pop_front());
            if (acc) begin
                e.ctrl = in_ctrl;
                e.alu  = in_alu;
                e.b    = in_b;
                e.rn   = in_rn;
                q.push_back(e);
            end
            if (q.size() > 0) last = q[0];
            mrdy = q.size() < 2;
        end
    endtask

    initial begin
        logic       ev;
        logic [2:0] ec;
        forever begin
            @(negedge clock);
            if (chk_en) begin
                ev = q.size() > 0;
                ec = last.ctrl & ~(ev ? 3'b000 : 3'b101);
                chk("m_out_valid", 64'(out_valid), 64'(ev));
                chk("m_in_ready", 64'(in_ready), 64'(mrdy));
                chk("m_occupancy", 64'(occupancy), 64'(q.size()));
                chk("m_out_ctrl", 64'(out_ctrl), 64'(ec));
                chk("m_out_alu", 64'(out_alu), 64'(last.alu));
                chk("m_out_b", 64'(out_b), 64'(last.b));
                chk("m_out_rn", 64'(out_rn), 64'(last.rn));
            end
        end
    end

    task automatic cyc(input logic v, input logic [2:0] c, input logic [31:0] a,
                       input logic r, input logic f, input logic rs);
        in_valid  = v;
        in_ctrl   = c;
        in_alu    = a;
        in_b      = $urandom;
        in_rn     = 5'($urandom);
        out_ready = r;
        flush     = f;
        reset     = rs;
        @(posedge clock);
        model_step();
        chk_en = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        {reset, flush, in_valid, out_ready} = 4'b1000;
        in_ctrl = '0; in_alu = '0; in_b = '0; in_rn = '0;
        {w_reset, w_flush, w_in_valid, w_out_ready} = 4'b1000;
        w_in_ctrl = '0; w_in_alu = '0; w_in_b = '0; w_in_rn = '0;

        // 1: reset then stream
        cyc(0, 3'b000, 32'h0, 1, 0, 1);
        cyc(0, 3'b000, 32'h0, 1, 0, 1);
        w_reset = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_alu", 64'(out_alu), 64'd0);
        chk("rst_ctrl", 64'(out_ctrl), 64'd0);
        cyc(1, 3'b001, 32'h10, 1, 0, 0);
        chk("s1_alu10", 64'(out_alu), 64'h10);
        chk("s1_valid", 64'(out_valid), 64'd1);
        cyc(1, 3'b001, 32'h11, 1, 0, 0);
        chk("s1_alu11", 64'(out_alu), 64'h11);
        chk("s1_occ", 64'(occupancy), 64'd1);
        cyc(1, 3'b001, 32'h12, 1, 0, 0);
        chk("s1_alu12", 64'(out_alu), 64'h12);
        chk("s1_ready", 64'(in_ready), 64'd1);
        cyc(0, 3'b000, 32'h0, 1, 0, 0);
        chk("s1_empty", 64'(out_valid), 64'd0);

        // 2: back-pressure
        cyc(1, 3'b000, 32'hA, 0, 0, 0);
        cyc(1, 3'b000, 32'hB, 0, 0, 0);
        chk("s2_occ2", 64'(occupancy), 64'd2);
        chk("s2_ready0", 64'(in_ready), 64'd0);
        cyc(1, 3'b000, 32'hC, 0, 0, 0);
        chk("s2_holdA", 64'(out_alu), 64'hA);
        chk("s2_hold_occ", 64'(occupancy), 64'd2);
        cyc(1, 3'b000, 32'hC, 1, 0, 0);
        chk("s2_outB", 64'(out_alu), 64'hB);
        chk("s2_ready1", 64'(in_ready), 64'd1);
        cyc(1, 3'b000, 32'hC, 1, 0, 0);
        chk("s2_outC", 64'(out_alu), 64'hC);
        cyc(0, 3'b000, 32'h0, 1, 0, 0);
        chk("s2_drained", 64'(out_valid), 64'd0);

        // 3: bubble masking
        cyc(1, 3'b111, 32'h33, 1, 0, 0);
        chk("s3_ctrl_live", 64'(out_ctrl), 64'b111);
        cyc(0, 3'b000, 32'h0, 1, 0, 0);
        chk("s3_ctrl_masked", 64'(out_ctrl), 64'b010);

        // 4: flush while full
        cyc(1, 3'b001, 32'h1, 0, 0, 0);
        cyc(1, 3'b001, 32'h2, 0, 0, 0);
        chk("s4_full", 64'(occupancy), 64'd2);
        cyc(1, 3'b001, 32'hD, 0, 1, 0);
        chk("s4_valid0", 64'(out_valid), 64'd0);
        chk("s4_occ0", 64'(occupancy), 64'd0);
        chk("s4_ready1", 64'(in_ready), 64'd1);
        cyc(0, 3'b000, 32'h0, 1, 0, 0);
        chk("s4_noD", 64'(out_valid), 64'd0);

        // 5: reset over flush mid-stall
        cyc(1, 3'b111, 32'h5, 0, 0, 0);
        cyc(1, 3'b111, 32'h6, 0, 0, 0);
        cyc(1, 3'b111, 32'h7, 0, 1, 1);
        chk("s5_alu", 64'(out_alu), 64'd0);
        chk("s5_b", 64'(out_b), 64'd0);
        chk("s5_rn", 64'(out_rn), 64'd0);
        chk("s5_ctrl", 64'(out_ctrl), 64'd0);
        chk("s5_occ", 64'(occupancy), 64'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) != 0, 3'($urandom), $urandom, ($urandom % 3) != 0,
                ($urandom % 60) == 0, ($urandom % 250) == 0);
        end

        // 6: wide parameter set
        w_in_valid  = 1'b1;
        w_in_ctrl   = 4'b1111;
        w_in_alu    = 64'hDEADBEEF_CAFEF00D;
        w_in_b      = 64'h01234567_89ABCDEF;
        w_in_rn     = 6'h3F;
        w_out_ready = 1'b1;
        cyc(0, 3'b000, 32'h0, 1, 0, 0);
        w_in_valid = 1'b0;
        chk("s6_valid", 64'(w_out_valid), 64'd1);
        chk("s6_alu", w_out_alu, 64'hDEADBEEF_CAFEF00D);
        chk("s6_b", w_out_b, 64'h01234567_89ABCDEF);
        chk("s6_rn", 64'(w_out_rn), 64'h3F);
        chk("s6_ctrl", 64'(w_out_ctrl), 64'hF);
        cyc(0, 3'b000, 32'h0, 1, 0, 0);
        chk("s6_bubble_valid", 64'(w_out_valid), 64'd0);
        chk("s6_bubble_ctrl", 64'(w_out_ctrl), 64'b0110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
